// File: rtl/moving_average_param.sv
// rtl/moving_average_param.sv - parametrised boxcar / EMA moving averager with primed flag and flush
module moving_average_param #(
    parameter int DATA_W       = 10,
    parameter int LOG2_MAX_WIN = 4,
    parameter int SEL_W        = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              strobe_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [SEL_W-1:0]  win_sel,
    input  logic              mode,
    input  logic              clear,
    output logic [DATA_W-1:0] data_out,
    output logic              strobe_out,
    output logic              primed
);

    localparam int DEPTH = 1 << LOG2_MAX_WIN;
    localparam int ACC_W = DATA_W + LOG2_MAX_WIN;
    localparam int K_W   = $clog2(LOG2_MAX_WIN + 1);
    localparam int CNT_W = LOG2_MAX_WIN + 1;

    logic                    strobe_q;
    logic                    sample_evt;
    logic [K_W-1:0]          k_reg;
    logic [K_W-1:0]          k_eff;
    logic                    mode_reg;
    logic                    settings_chg;
    logic [31:0]             win_sel_ext;
    logic [CNT_W-1:0]        win_len;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_base;
    logic [ACC_W-1:0]        acc_next;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        count_base;
    logic [CNT_W-1:0]        count_next;
    logic [LOG2_MAX_WIN-1:0] wr_ptr;
    logic [LOG2_MAX_WIN-1:0] rd_ptr;
    logic [DATA_W-1:0]       hist [DEPTH];
    logic [DATA_W-1:0]       oldest;
    logic [DATA_W-1:0]       data_next;
    logic                    primed_next;

    assign sample_evt  = ena & strobe_in & ~strobe_q;
    assign win_sel_ext = 32'(win_sel);

    always_comb begin
        k_eff = K_W'(win_sel_ext);
        if (win_sel_ext > 32'(LOG2_MAX_WIN)) begin
            k_eff = K_W'(LOG2_MAX_WIN);
        end
    end

    assign settings_chg = (k_eff != k_reg) || (mode != mode_reg);
    assign win_len      = CNT_W'(1) << k_eff;

    // At the full window the slot leaving the window is the one about to be overwritten.
    assign rd_ptr = wr_ptr - win_len[LOG2_MAX_WIN-1:0];

    always_comb begin
        oldest     = settings_chg ? '0 : hist[rd_ptr];
        acc_base   = settings_chg ? '0 : acc;
        count_base = settings_chg ? '0 : count;
        if (mode) begin
            acc_next = acc_base - (acc_base >> k_eff) + ACC_W'(data_in);
        end else begin
            acc_next = acc_base + ACC_W'(data_in) - ACC_W'(oldest);
        end
        count_next = count_base;
        if (count_base != CNT_W'(DEPTH)) begin
            count_next = count_base + CNT_W'(1);
        end
        data_next   = DATA_W'(acc_next >> k_eff);
        primed_next = (count_next >= win_len);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            strobe_q   <= 1'b0;
            strobe_out <= 1'b0;
            data_out   <= '0;
            primed     <= 1'b0;
            acc        <= '0;
            count      <= '0;
            wr_ptr     <= '0;
            k_reg      <= '0;
            mode_reg   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else begin
            strobe_q   <= strobe_in;
            strobe_out <= 1'b0;
            if (clear) begin
                // clear takes priority over a coincident sample event
                acc      <= '0;
                count    <= '0;
                primed   <= 1'b0;
                data_out <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    hist[i] <= '0;
                end
            end else if (sample_evt) begin
                k_reg      <= k_eff;
                mode_reg   <= mode;
                acc        <= acc_next;
                count      <= count_next;
                primed     <= primed_next;
                data_out   <= data_next;
                strobe_out <= 1'b1;
                if (settings_chg) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        hist[i] <= '0;
                    end
                end
                hist[wr_ptr] <= data_in;
                wr_ptr       <= wr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_moving_average_param.sv
// tb/tb_moving_average_param.sv - self-checking bench for moving_average_param
module tb_moving_average_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       strobe_in;
    logic [9:0] data_in;
    logic [2:0] win_sel;
    logic       mode;
    logic       clear;
    logic [9:0] data_out;
    logic       strobe_out;
    logic       primed;

    always #5 clk = ~clk;

    moving_average_param #(
        .DATA_W(10),
        .LOG2_MAX_WIN(4),
        .SEL_W(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .strobe_in(strobe_in),
        .data_in(data_in),
        .win_sel(win_sel),
        .mode(mode),
        .clear(clear),
        .data_out(data_out),
        .strobe_out(strobe_out),
        .primed(primed)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: history of samples since the last flush, sums and recurrences in plain integers.
    int     m_k;
    int     m_mode;
    int     m_hist[$];
    longint m_acc;
    int     m_out;
    int     m_primed;

    function automatic void model_clear();
        m_hist.delete();
        m_acc    = 0;
        m_out    = 0;
        m_primed = 0;
    endfunction

    function automatic void model_reset();
        model_clear();
        m_k    = 0;
        m_mode = 0;
    endfunction

    function automatic void model_event(input int x, input int ws, input int md);
        int     keff;
        int     n;
        longint sum;
        keff = (ws > 4) ? 4 : ws;
        n    = 1 << keff;
        if (keff != m_k || md != m_mode) begin
            m_hist.delete();
            m_acc = 0;
        end
        m_k    = keff;
        m_mode = md;
        m_hist.push_back(x);
        if (m_hist.size() > 16) void'(m_hist.pop_front());
        if (md == 0) begin
            sum = 0;
            for (int i = 0; i < n && i < m_hist.size(); i++) begin
                sum += m_hist[m_hist.size() - 1 - i];
            end
            m_out = int'(sum / n);
        end else begin
            m_acc = m_acc - (m_acc / (longint'(1) << keff)) + x;
            m_out = int'(m_acc / (longint'(1) << keff));
        end
        m_primed = (m_hist.size() >= n) ? 1 : 0;
    endfunction

    logic [9:0] got_out;
    logic       got_strobe;
    logic       got_strobe2;
    logic       got_primed;
    int         pulses;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int x, input int ws, input int md);
        data_in   = 10'(x);
        win_sel   = 3'(ws);
        mode      = md[0];
        strobe_in = 1'b1;
        step();
        got_out    = data_out;
        got_strobe = strobe_out;
        got_primed = primed;
        strobe_in  = 1'b0;
        step();
        got_strobe2 = strobe_out;
        model_event(x, ws, md);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_clear();
    endtask

    typedef struct {
        int x;
        int ws;
        int md;
        int exp_out;
        int exp_primed;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int ws_r;
        int md_r;
        int x_r;

        vecs.push_back('{0, 1, 0, 0, 0});
        vecs.push_back('{1023, 1, 0, 511, 1});
        vecs.push_back('{1023, 1, 0, 1023, 1});
        vecs.push_back('{1023, 2, 1, 255, 0});
        vecs.push_back('{1023, 2, 1, 447, 0});
        vecs.push_back('{1023, 2, 1, 591, 0});
        vecs.push_back('{1023, 2, 1, 699, 1});
        vecs.push_back('{800, 2, 0, 200, 0});
        vecs.push_back('{800, 2, 0, 400, 0});
        vecs.push_back('{800, 2, 0, 600, 0});
        vecs.push_back('{800, 2, 0, 800, 1});
        vecs.push_back('{800, 2, 0, 800, 1});
        vecs.push_back('{400, 3, 0, 50, 0});
        for (int j = 2; j <= 8; j++) vecs.push_back('{400, 3, 0, 50 * j, (j >= 8) ? 1 : 0});
        vecs.push_back('{160, 7, 0, 10, 0});
        vecs.push_back('{160, 4, 0, 20, 0});

        rst_n     = 1'b0;
        ena       = 1'b1;
        strobe_in = 1'b0;
        data_in   = '0;
        win_sel   = '0;
        mode      = 1'b0;
        clear     = 1'b0;
        model_reset();

        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            strobe_in = ~strobe_in;
            data_in   = 10'(100 * (i + 1));
            step();
            pulses += int'(strobe_out);
        end
        check("reset_no_strobe", pulses, 0);
        check("reset_data_out", data_out, 0);
        check("reset_primed", primed, 0);
        strobe_in = 1'b0;
        rst_n     = 1'b1;
        step();

        foreach (vecs[i]) begin
            pulse(vecs[i].x, vecs[i].ws, vecs[i].md);
            check($sformatf("vec%0d_out", i), got_out, vecs[i].exp_out);
            check($sformatf("vec%0d_primed", i), got_primed, vecs[i].exp_primed);
            check($sformatf("vec%0d_strobe", i), got_strobe, 1);
            check($sformatf("vec%0d_strobe_drop", i), got_strobe2, 0);
        end

        do_clear();
        check("clear_data_out", data_out, 0);
        check("clear_primed", primed, 0);
        for (int i = 0; i < 16; i++) begin
            pulse(0, 4, 0);
            check($sformatf("k4_zero%0d_out", i), got_out, 0);
            check($sformatf("k4_zero%0d_primed", i), got_primed, (i == 15) ? 1 : 0);
        end
        for (int j = 1; j <= 20; j++) begin
            pulse(1023, 4, 0);
            check($sformatf("k4_step%0d_out", j), got_out, (j >= 16) ? 1023 : (1023 * j) / 16);
            check($sformatf("k4_step%0d_primed", j), got_primed, 1);
        end

        data_in   = 10'd500;
        strobe_in = 1'b1;
        pulses    = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            pulses += int'(strobe_out);
        end
        strobe_in = 1'b0;
        step();
        pulses += int'(strobe_out);
        model_event(500, 4, 0);
        check("held_high_one_event", pulses, 1);
        check("held_high_out", data_out, m_out);

        ena       = 1'b0;
        data_in   = 10'd7;
        pulses    = 0;
        strobe_in = 1'b1;
        step();
        pulses += int'(strobe_out);
        step();
        pulses += int'(strobe_out);
        ena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            pulses += int'(strobe_out);
        end
        strobe_in = 1'b0;
        step();
        pulses += int'(strobe_out);
        check("ena_low_no_strobe", pulses, 0);
        check("ena_low_hold_out", data_out, m_out);

        data_in   = 10'd900;
        strobe_in = 1'b1;
        clear     = 1'b1;
        step();
        check("clear_evt_strobe", strobe_out, 0);
        check("clear_evt_out", data_out, 0);
        check("clear_evt_primed", primed, 0);
        clear     = 1'b0;
        strobe_in = 1'b0;
        step();
        check("clear_evt_strobe_after", strobe_out, 0);
        model_clear();

        ws_r = 2;
        md_r = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(9) == 0) ws_r = $urandom_range(7);
            if ($urandom_range(19) == 0) md_r = $urandom_range(1);
            if ($urandom_range(24) == 0) do_clear();
            case ($urandom_range(3))
                0:       x_r = 0;
                1:       x_r = 1023;
                default: x_r = $urandom_range(1023);
            endcase
            pulse(x_r, ws_r, md_r);
            check($sformatf("rand%0d_out", i), got_out, m_out);
            check($sformatf("rand%0d_primed", i), got_primed, m_primed);
            check($sformatf("rand%0d_strobe", i), got_strobe, 1);
            for (int g = $urandom_range(2); g > 0; g--) step();
        end

        rst_n     = 1'b0;
        strobe_in = 1'b1;
        data_in   = 10'd333;
        step();
        check("midreset_out", data_out, 0);
        check("midreset_primed", primed, 0);
        check("midreset_strobe", strobe_out, 0);
        rst_n     = 1'b1;
        strobe_in = 1'b0;
        step();
        model_reset();
        pulse(100, 0, 0);
        check("post_reset_out", got_out, m_out);
        check("post_reset_primed", got_primed, m_primed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
